// File: rtl/alu_seq_divider.sv
// alu_seq_divider: multi-cycle N-bit restoring divider, signed or unsigned,
// one quotient bit per cycle, start/busy/done handshake.
// Optional build macro DIV_EARLY_OUT_EN: when |B| > |A| the quotient is
// known to be zero, so the iterative phase is skipped.
module alu_seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0]  ONE_N  = N'(1);
  localparam logic [N:0]    ONE_N1 = (N+1)'(1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [N:0]    rem_q;      // partial remainder magnitude (N+1 bits)
  logic [N-1:0]  dvd_q;      // dividend bits shift out, quotient bits shift in
  logic [N:0]    dsr_q;      // divisor magnitude
  logic          qneg_q, rneg_q, dbz_hit_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, dbz_q;
  logic [N-1:0]  q_q, r_q;

  // operand magnitudes, N+1 bits so |-2^(N-1)| is exact
  logic          a_neg, b_neg, b_zero, early, accept;
  logic [N:0]    a_sext, b_sext, mag_a, mag_b;
  logic [N+1:0]  rem_sh, trial;
  logic          fits;

  // operand decode and one restoring-division step
  always_comb begin
    a_neg  = is_signed & A[N-1];
    b_neg  = is_signed & B[N-1];
    a_sext = {a_neg, A};
    b_sext = {b_neg, B};
    mag_a  = a_neg ? (~a_sext + ONE_N1) : a_sext;
    mag_b  = b_neg ? (~b_sext + ONE_N1) : b_sext;
    b_zero = (B == '0);
`ifdef DIV_EARLY_OUT_EN
    early  = !b_zero && (mag_b > mag_a);
`else
    early  = 1'b0;
`endif
    accept = (state_q == S_IDLE) && start && !done_q;
    rem_sh = {rem_q, dvd_q[N-1]};
    trial  = rem_sh - {1'b0, dsr_q};
    fits   = !trial[N+1];
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (b_zero)     state_d = S_DONE;
        else if (early) state_d = S_FIX;
        else            state_d = S_CALC;
      end
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dbz_hit_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: if (accept) begin
          // divide-by-zero parks the raw dividend in rem_q for R
          rem_q     <= b_zero ? {1'b0, A} : (early ? mag_a : '0);
          dvd_q     <= early ? '0 : mag_a[N-1:0];
          dsr_q     <= mag_b;
          qneg_q    <= a_neg ^ b_neg;
          rneg_q    <= a_neg;
          dbz_hit_q <= b_zero;
          cnt_q     <= CW'(N-1);
          dbz_q     <= 1'b0;
        end
        S_CALC: begin
          rem_q <= fits ? trial[N:0] : rem_sh[N:0];
          dvd_q <= {dvd_q[N-2:0], fits};
          if (cnt_q != '0) cnt_q <= cnt_q - ONE_C;
        end
        S_FIX: begin
          q_q <= qneg_q ? (~dvd_q + ONE_N) : dvd_q;
          r_q <= rneg_q ? (~rem_q[N-1:0] + ONE_N) : rem_q[N-1:0];
        end
        S_DONE: if (dbz_hit_q) begin
          q_q   <= '1;
          r_q   <= rem_q[N-1:0];
          dbz_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule
